// File: rtl/lvdc_alu_pkg.sv
// rtl/lvdc_alu_pkg.sv - op/state encodings and per-op carry preset for the serial ALU
package lvdc_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_RSU  = 3'b010,
        OP_AND  = 3'b011,
        OP_XOR  = 3'b100,
        OP_CLA  = 3'b101,
        OP_RES6 = 3'b110,
        OP_RES7 = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // Subtraction is two's complement: the inverted operand needs a +1 via carry-in.
    function automatic logic carry_preset(input alu_op_e op);
        return (op == OP_SUB) || (op == OP_RSU);
    endfunction

    function automatic logic is_arith(input alu_op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_RSU);
    endfunction

endpackage

// File: rtl/lvdc_serial_adder.sv
// rtl/lvdc_serial_adder.sv - bit-serial full adder with carry flop, input inversion and overflow tap
module lvdc_serial_adder #(
    parameter bit OVF_EN = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_load,
    input  logic i_load_val,
    input  logic i_en,
    input  logic i_a,
    input  logic i_b,
    input  logic i_inv_a,
    input  logic i_inv_b,
    output logic o_sum,
    output logic o_ovf_tap
);

    logic r_carry;
    logic w_a;
    logic w_b;
    logic w_cout;

    assign w_a    = i_a ^ i_inv_a;
    assign w_b    = i_b ^ i_inv_b;
    assign o_sum  = w_a ^ w_b ^ r_carry;
    assign w_cout = (w_a & w_b) | (w_a & r_carry) | (w_b & r_carry);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_carry <= 1'b0;
        end else if (i_load) begin
            r_carry <= i_load_val;
        end else if (i_en) begin
            r_carry <= w_cout;
        end
    end

    // Meaningful only while the MSB is being consumed: carry-in XOR carry-out of that bit.
    generate
        if (OVF_EN) begin : g_ovf
            assign o_ovf_tap = r_carry ^ w_cout;
        end else begin : g_no_ovf
            assign o_ovf_tap = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/lvdc_serial_alu.sv
// rtl/lvdc_serial_alu.sv - bit-serial ALU with word sequencer and end-of-word flags; LVDC_ALU_OVF_EN enables ovf
module lvdc_serial_alu
    import lvdc_alu_pkg::*;
#(
    parameter int WIDTH = 26
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [2:0] op,
    input  logic       bit_en,
    input  logic       abit,
    input  logic       mbit,
    output logic       rbit,
    output logic       rvalid,
    output logic       busy,
    output logic       done,
    output logic       zero,
    output logic       sign,
    output logic       ovf
);

`ifdef LVDC_ALU_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    alu_state_e    r_state;
    alu_op_e       r_op;
    logic [CW-1:0] r_cnt;
    logic          r_zacc;
    logic          r_rbit;
    logic          r_rvalid;
    logic          r_busy;
    logic          r_done;
    logic          r_zero;
    logic          r_sign;
    logic          r_ovf;

    logic w_accept;
    logic w_step;
    logic w_sum;
    logic w_ovf_tap;
    logic w_res;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_step   = (r_state == ST_RUN) && bit_en;

    lvdc_serial_adder #(
        .OVF_EN (OVF_EN)
    ) u_adder (
        .clk        (clk),
        .rstn       (rstn),
        .i_load     (w_accept),
        .i_load_val (carry_preset(alu_op_e'(op))),
        .i_en       (w_step),
        .i_a        (abit),
        .i_b        (mbit),
        .i_inv_a    (r_op == OP_RSU),
        .i_inv_b    (r_op == OP_SUB),
        .o_sum      (w_sum),
        .o_ovf_tap  (w_ovf_tap)
    );

    always_comb begin
        w_res = mbit;
        case (r_op)
            OP_ADD, OP_SUB, OP_RSU: w_res = w_sum;
            OP_AND:                 w_res = abit & mbit;
            OP_XOR:                 w_res = abit ^ mbit;
            default:                w_res = mbit;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_ADD;
            r_cnt    <= '0;
            r_zacc   <= 1'b0;
            r_rbit   <= 1'b0;
            r_rvalid <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_zero   <= 1'b0;
            r_sign   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_op    <= alu_op_e'(op);
                        r_cnt   <= '0;
                        r_zacc  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_zero  <= 1'b0;
                        r_sign  <= 1'b0;
                        r_ovf   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (bit_en) begin
                        r_rbit   <= w_res;
                        r_rvalid <= 1'b1;
                        if (w_res) begin
                            r_zacc <= 1'b0;
                        end
                        // Flags are taken from the live MSB, not the registered copy.
                        if (r_cnt == LAST) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_zero  <= r_zacc & ~w_res;
                            r_sign  <= w_res;
                            r_ovf   <= is_arith(r_op) & w_ovf_tap;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rbit   = r_rbit;
    assign rvalid = r_rvalid;
    assign busy   = r_busy;
    assign done   = r_done;
    assign zero   = r_zero;
    assign sign   = r_sign;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_lvdc_serial_alu.sv
// tb/tb_lvdc_serial_alu.sv - self-checking bench for lvdc_serial_alu at WIDTH 8 and 26
module tb_lvdc_serial_alu;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic [2:0] op;
    logic       bit_en;
    logic       abit;
    logic       mbit;

    logic o8_rbit, o8_rvalid, o8_busy, o8_done, o8_zero, o8_sign, o8_ovf;
    logic o26_rbit, o26_rvalid, o26_busy, o26_done, o26_zero, o26_sign, o26_ovf;

    int n_checks = 0;
    int n_errors = 0;
    bit sel26 = 1'b0;

    always #5 clk = ~clk;

    lvdc_serial_alu #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rstn(rstn), .start(start), .op(op), .bit_en(bit_en),
        .abit(abit), .mbit(mbit), .rbit(o8_rbit), .rvalid(o8_rvalid),
        .busy(o8_busy), .done(o8_done), .zero(o8_zero), .sign(o8_sign), .ovf(o8_ovf)
    );

    lvdc_serial_alu #(.WIDTH(26)) u_dut26 (
        .clk(clk), .rstn(rstn), .start(start), .op(op), .bit_en(bit_en),
        .abit(abit), .mbit(mbit), .rbit(o26_rbit), .rvalid(o26_rvalid),
        .busy(o26_busy), .done(o26_done), .zero(o26_zero), .sign(o26_sign), .ovf(o26_ovf)
    );

    wire s_rbit   = sel26 ? o26_rbit   : o8_rbit;
    wire s_rvalid = sel26 ? o26_rvalid : o8_rvalid;
    wire s_busy   = sel26 ? o26_busy   : o8_busy;
    wire s_done   = sel26 ? o26_done   : o8_done;
    wire s_zero   = sel26 ? o26_zero   : o8_zero;
    wire s_sign   = sel26 ? o26_sign   : o8_sign;
    wire s_ovf    = sel26 ? o26_ovf    : o8_ovf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_res(input int w, input logic [2:0] o,
                                              input logic [63:0] a, input logic [63:0] m);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        case (o)
            3'd0:    return (a + m) & mask;
            3'd1:    return (a - m) & mask;
            3'd2:    return (m - a) & mask;
            3'd3:    return a & m & mask;
            3'd4:    return (a ^ m) & mask;
            default: return m & mask;
        endcase
    endfunction

    // Signed overflow from operand and result signs.
    function automatic logic model_ovf(input int w, input logic [2:0] o,
                                       input logic [63:0] a, input logic [63:0] m);
`ifdef LVDC_ALU_OVF_EN
        logic [63:0] r;
        logic sa, sm, sr;
        r  = model_res(w, o, a, m);
        sa = a[w-1];
        sm = m[w-1];
        sr = r[w-1];
        case (o)
            3'd0:    return (sa == sm) && (sr != sa);
            3'd1:    return (sa != sm) && (sr != sa);
            3'd2:    return (sm != sa) && (sr != sm);
            default: return 1'b0;
        endcase
`else
        return 1'b0;
`endif
    endfunction

    task automatic run_word(input string tag, input int w, input logic [2:0] o,
                            input logic [63:0] a, input logic [63:0] m,
                            input bit stall, input bit mid_start, input int abort_at);
        int          cyc;
        int          k;
        int          nval;
        int          done_cyc;
        logic [63:0] res;
        logic [63:0] exp;
        logic        fz, fs, fo, en;
        sel26 = (w == 26);
        @(negedge clk);
        start = 1'b1; op = o; bit_en = 1'b0; abit = 1'($urandom); mbit = 1'($urandom);
        cyc = 0; k = 0; nval = 0; done_cyc = 0; res = '0; fz = 0; fs = 0; fo = 0;
        while (done_cyc == 0 && cyc < 4 * w + 10) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check({tag, "/busy_at_1"}, 64'(s_busy), 64'd1);
            if (s_rvalid) begin
                if (nval < 64) res[nval] = s_rbit;
                nval++;
            end
            if (s_done) begin
                done_cyc = cyc; fz = s_zero; fs = s_sign; fo = s_ovf;
            end
            start = mid_start && (cyc == 3);
            if (mid_start && cyc == 3) op = ~o;
            if (abort_at >= 0 && k == abort_at) begin
                rstn = 1'b0;
                #1;
                check({tag, "/rst_async_outs"},
                      64'({o26_rbit, o26_rvalid, o26_busy, o26_done, o26_zero, o26_sign, o26_ovf,
                           o8_rbit, o8_rvalid, o8_busy, o8_done, o8_zero, o8_sign, o8_ovf}), 64'd0);
                start = 1'b0; bit_en = 1'b0;
                @(negedge clk);
                rstn = 1'b1;
                return;
            end
            en     = (k < w) && (!stall || cyc[0]);
            bit_en = en;
            abit   = en ? a[k] : 1'($urandom);
            mbit   = en ? m[k] : 1'($urandom);
            if (en) k++;
        end
        start = 1'b0; bit_en = 1'b0;
        exp = model_res(w, o, a, m);
        check({tag, "/result"}, res, exp);
        check({tag, "/rvalid_count"}, 64'(nval), 64'(w));
        check({tag, "/done_latency"}, 64'(done_cyc), stall ? 64'(2 * w) : 64'(w + 1));
        check({tag, "/zero"}, 64'(fz), 64'(exp == 64'd0));
        check({tag, "/sign"}, 64'(fs), 64'(exp[w-1]));
        check({tag, "/ovf"}, 64'(fo), 64'(model_ovf(w, o, a, m)));
        @(negedge clk);
        check({tag, "/idle_flags_held"}, 64'({s_busy, s_done, s_zero, s_sign}),
              64'({1'b0, 1'b0, exp == 64'd0, exp[w-1]}));
    endtask

    initial begin
        logic [63:0] ra, rm;
        rstn = 1'b0; start = 1'b0; op = 3'd0; bit_en = 1'b0; abit = 1'b0; mbit = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs8", 64'({o8_rbit, o8_rvalid, o8_busy, o8_done, o8_zero, o8_sign, o8_ovf}), 64'd0);
        check("reset_outs26", 64'({o26_rbit, o26_rvalid, o26_busy, o26_done, o26_zero, o26_sign, o26_ovf}), 64'd0);
        rstn = 1'b1;

        run_word("add_05_03", 8, 3'd0, 64'h05, 64'h03, 1'b0, 1'b0, -1);
        run_word("sub_05_05", 8, 3'd1, 64'h05, 64'h05, 1'b0, 1'b0, -1);
        run_word("rsu_03_01", 8, 3'd2, 64'h03, 64'h01, 1'b0, 1'b0, -1);
        run_word("and_f0_3c", 8, 3'd3, 64'hF0, 64'h3C, 1'b0, 1'b0, -1);
        run_word("xor_f0_3c", 8, 3'd4, 64'hF0, 64'h3C, 1'b0, 1'b0, -1);
        run_word("cla_5a",    8, 3'd5, 64'hA7, 64'h5A, 1'b0, 1'b0, -1);
        run_word("op7_5a",    8, 3'd7, 64'h11, 64'h5A, 1'b0, 1'b0, -1);
        run_word("add_ovf",   8, 3'd0, 64'h7F, 64'h01, 1'b0, 1'b0, -1);
        run_word("sub_ovf",   8, 3'd1, 64'h80, 64'h01, 1'b0, 1'b0, -1);
        run_word("stall_add", 8, 3'd0, 64'h05, 64'h03, 1'b1, 1'b1, -1);

        for (int i = 0; i < 16; i++) begin
            ra = 64'($urandom_range(0, 255));
            rm = 64'($urandom_range(0, 255));
            run_word($sformatf("rand8_%0d", i), 8, 3'($urandom_range(0, 7)), ra, rm,
                     1'($urandom), 1'($urandom), -1);
        end

        @(negedge clk); rstn = 1'b0;
        @(negedge clk); rstn = 1'b1;
        run_word("w26_abort", 26, 3'd0, 64'h1234567, 64'h0ABCDEF, 1'b0, 1'b0, 4);
        run_word("w26_add", 26, 3'd0, 64'h1234567, 64'h0ABCDEF, 1'b0, 1'b0, -1);
        for (int i = 0; i < 4; i++) begin
            ra = 64'($urandom) & 64'h3FFFFFF;
            rm = 64'($urandom) & 64'h3FFFFFF;
            run_word($sformatf("rand26_%0d", i), 26, 3'($urandom_range(0, 7)), ra, rm,
                     1'($urandom), 1'b0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
